multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle main decoder.
- Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, and stalls on a `mem_ready` handshake from the shared instruction/data memory.
- Adds `addi`/`bne` support, an illegal-opcode halt, a retired-instruction counter and an optional memory watchdog.
- Sits between the IR opcode field and the multi-cycle datapath muxes and enables.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- TIMEOUT_CYCLES, 16, consecutive `mem_ready`-low cycles before a bus error. Used only with MEM_TIMEOUT_EN. Must be ≥1.

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH completes.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by the ALU zero flag.
- branch_ne  out  1  invert the zero qualification (bne).
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback data: 1 = MDR, 0 = ALUOut.
- reg_dst  out  1  destination: 1 = rd, 0 = rt.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B input: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- halted  out  1  FSM is in HALT.
- bus_error  out  1  sticky watchdog fault.
- instr_count  out  CNT_W  retired instructions, wraps.
- state_dbg  out  4  current state encoding.

Behaviour:
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, bne = 000101, j = 000010, addi = 001000. Any other opcode is illegal.
- State encoding: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXECUTE 7, R_WB 8, BRANCH 9, JUMP 10, ADDI_EXEC 11, ADDI_WB 12, HALT 13.
- Reset (async, any time, including mid-memory-access):
  - state = IDLE, instr_count = 0, bus_error = 0.
  - All control outputs are 0 from the reset assertion edge.
- Control outputs are decoded from the state register only. The exceptions are ir_write and pc_write in FETCH, which are also gated by mem_ready. Every output not listed for a state is 0.
- IDLE: no outputs asserted. Goes to FETCH next cycle.
- FETCH:
  - Asserts mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write = pc_write = mem_ready.
  - Goes to DECODE when mem_ready, otherwise stays.
- DECODE:
  - Asserts alu_src_a = 0, alu_src_b = 11, alu_op = 00.
  - Next state by opcode: R → EXECUTE; lw/sw → MEM_ADDR; beq/bne → BRANCH; j → JUMP; addi → ADDI_EXEC; illegal → HALT.
- MEM_ADDR:
  - Asserts alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: asserts mem_read = 1, iord = 1. Goes to MEM_WB on mem_ready, otherwise stays.
- MEM_WB: asserts reg_write = 1, mem_to_reg = 1, reg_dst = 0. Goes to FETCH.
- MEM_WRITE: asserts mem_write = 1, iord = 1. Goes to FETCH on mem_ready, otherwise stays.
- EXECUTE: asserts alu_src_a = 1, alu_src_b = 00, alu_op = 10. Goes to R_WB.
- R_WB: asserts reg_write = 1, reg_dst = 1, mem_to_reg = 0. Goes to FETCH.
- BRANCH:
  - Asserts alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01.
  - branch_ne = (opcode == bne).
  - Goes to FETCH.
- JUMP: asserts pc_write = 1, pc_source = 10. Goes to FETCH.
- ADDI_EXEC: asserts alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to ADDI_WB.
- ADDI_WB: asserts reg_write = 1, reg_dst = 0, mem_to_reg = 0. Goes to FETCH.
- HALT: halted = 1, all other controls 0. Only reset exits HALT.
- Cycle counts with zero wait states: R = 4, lw = 5, sw = 4, beq/bne = 3, j = 3, addi = 4. Each mem_ready-low cycle adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- instr_count:
  - Increments by 1 on every transition into FETCH from a completing state: MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB.
  - Does not increment on IDLE → FETCH or on HALT entry.
  - Wraps from 2^CNT_W − 1 to 0.
- mem_ready is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - It increments on each cycle in those states with mem_ready = 0.
  - When it reaches TIMEOUT_CYCLES with mem_ready still 0, the FSM goes to HALT and bus_error sets to 1. bus_error holds until reset.
  - mem_ready = 1 on the same cycle wins: normal advance, no error.
- When undefined: no counter, the FSM waits indefinitely, bus_error is tied 0.

Test Plan:
- Reset, then R-type (opcode 000000), mem_ready = 1 → states 0,1,2,7,8,1; reg_write = 1 and reg_dst = 1 in R_WB; instr_count = 1.
- lw with mem_ready low for 3 cycles in MEM_READ → MEM_READ held 4 cycles, mem_read = 1, iord = 1 throughout; MEM_WB asserts mem_to_reg = 1; instruction takes 8 cycles.
- bne (000101) → BRANCH asserts pc_write_cond = 1, branch_ne = 1, pc_source = 01, alu_op = 01. beq repeated → branch_ne = 0.
- Opcode 111111 → DECODE to HALT; halted = 1; all strobes 0 for 20 cycles; instr_count unchanged; rst_n pulse returns to IDLE.
- rst_n asserted mid-MEM_WRITE with mem_write = 1 → mem_write drops to 0 without waiting for a clock edge; state_dbg = 0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, mem_ready held 0 in FETCH → HALT after the 4th wait cycle; bus_error = 1. Without the macro → remains in FETCH; bus_error = 0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: bundles the opcode/memory handshake inputs and
// every control, status and debug output of the multi-cycle control unit.
// The slave modport is the control unit's view; master is the datapath/driver.
// CNT_W must match the CNT_W of the control unit it is connected to.
interface multicycle_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch_ne;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             halted;
    logic             bus_error;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       state_dbg;

    modport slave (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, halted, bus_error, instr_count, state_dbg
    );

    modport master (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, halted, bus_error, instr_count, state_dbg
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM that sequences fetch, decode, execute,
// memory and writeback for the multi-cycle datapath, stalling on mem_ready.
// Supports R-type, lw, sw, beq, bne, j and addi; any other opcode halts.
// Counts retired instructions (wrapping). Define MEM_TIMEOUT_EN to enable the
// memory watchdog that halts with a sticky bus_error after TIMEOUT_CYCLES
// consecutive mem_ready-low cycles; without it bus_error is tied low.
module multicycle_control_unit #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_control_unit_if.slave bus
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_EXECUTE   = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
    localparam logic [3:0] S_ADDI_EXEC = 4'd11;
    localparam logic [3:0] S_ADDI_WB   = 4'd12;
    localparam logic [3:0] S_HALT      = 4'd13;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("multicycle_control_unit: TIMEOUT_CYCLES must be at least 1");
    end

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             completing;
    logic             timeout_hit;

    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;

    // Next-state selection; memory states hold until mem_ready or a watchdog timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready)
                    state_d = S_DECODE;
                else if (timeout_hit)
                    state_d = S_HALT;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:           state_d = S_EXECUTE;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI:        state_d = S_ADDI_EXEC;
                    default:        state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (bus.mem_ready)
                    state_d = S_MEM_WB;
                else if (timeout_hit)
                    state_d = S_HALT;
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: begin
                if (bus.mem_ready)
                    state_d = S_FETCH;
                else if (timeout_hit)
                    state_d = S_HALT;
            end
            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase
    end

    // Retire an instruction whenever a completing state hands back to FETCH
    always_comb begin
        completing = (state_q == S_MEM_WB)  || (state_q == S_MEM_WRITE) ||
                     (state_q == S_R_WB)    || (state_q == S_BRANCH)    ||
                     (state_q == S_JUMP)    || (state_q == S_ADDI_WB);
        instr_count_d = instr_count_q;
        if (completing && (state_d == S_FETCH))
            instr_count_d = instr_count_q + 1'b1;
    end

    // State and retired-instruction counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic              in_wait_state;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              bus_error_q, bus_error_d;

    // Count consecutive stalled cycles; leaving or re-entering a wait state restarts from zero
    always_comb begin
        in_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                        (state_q == S_MEM_WRITE);
        timeout_hit   = in_wait_state && !bus.mem_ready && (wait_cnt_q == WAIT_LAST);
        wait_cnt_d    = '0;
        if (in_wait_state && !bus.mem_ready && !timeout_hit)
            wait_cnt_d = wait_cnt_q + 1'b1;
        bus_error_d   = bus_error_q | timeout_hit;
    end

    // Watchdog counter and sticky bus error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus.bus_error = bus_error_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.bus_error = 1'b0;
`endif

    // Moore control decode; only FETCH's IR/PC loads look at mem_ready
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = (bus.opcode == OP_BNE);
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.branch_ne     = branch_ne;
    assign bus.iord          = iord;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_dst       = reg_dst;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.pc_source     = pc_source;
    assign bus.halted        = (state_q == S_HALT);
    assign bus.instr_count   = instr_count_q;
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed-vector scoreboard bench for the
// multi-cycle control unit. The driver pushes the expected state, controls,
// counter and status for each cycle; a monitor pops and compares on the
// falling clock edge. Uses CNT_W = 4 so counter wrap is reachable and
// TIMEOUT_CYCLES = 4; the watchdog section follows MEM_TIMEOUT_EN.
module tb_multicycle_control_unit;

    localparam int CNT_W          = 4;
    localparam int TIMEOUT_CYCLES = 4;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_FETCH     = 4'd1;
    localparam logic [3:0] ST_DECODE    = 4'd2;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd3;
    localparam logic [3:0] ST_MEM_READ  = 4'd4;
    localparam logic [3:0] ST_MEM_WB    = 4'd5;
    localparam logic [3:0] ST_MEM_WRITE = 4'd6;
    localparam logic [3:0] ST_EXECUTE   = 4'd7;
    localparam logic [3:0] ST_R_WB      = 4'd8;
    localparam logic [3:0] ST_BRANCH    = 4'd9;
    localparam logic [3:0] ST_JUMP      = 4'd10;
    localparam logic [3:0] ST_ADDI_EXEC = 4'd11;
    localparam logic [3:0] ST_ADDI_WB   = 4'd12;
    localparam logic [3:0] ST_HALT      = 4'd13;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    typedef struct packed {
        logic [3:0]       st;
        ctrl_t            ctrl;
        logic [CNT_W-1:0] cnt;
        logic             halted;
        logic             berr;
    } exp_t;

    logic clk;
    logic rst_n;

    multicycle_control_unit_if #(.CNT_W(CNT_W)) bus_if ();

    multicycle_control_unit #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    exp_t             exp_q[$];
    string            name_q[$];
    int               total_cnt = 0;
    int               pass_cnt  = 0;
    logic [CNT_W-1:0] exp_cnt   = '0;
    logic             exp_berr  = 1'b0;

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for a state, built straight from the state table
    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                       input logic rdy);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.mem_read = 1'b1; c.alu_src_b = 2'b01;
                c.ir_write = rdy;  c.pc_write  = rdy;
            end
            ST_DECODE:    c.alu_src_b = 2'b11;
            ST_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ST_MEM_READ:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            ST_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            ST_MEM_WRITE: begin c.mem_write = 1'b1; c.iord = 1'b1; end
            ST_EXECUTE:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            ST_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            ST_BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
                c.pc_source = 2'b01; c.branch_ne = (op == OP_BNE);
            end
            ST_JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            ST_ADDI_EXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ST_ADDI_WB:   c.reg_write = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // Drive inputs for the current cycle, queue the expected response, advance one cycle
    task automatic applyStimulus(input logic [5:0] op, input logic rdy,
                                 input logic [3:0] st, input string nm);
        exp_t e;
        bus_if.opcode    = op;
        bus_if.mem_ready = rdy;
        e.st     = st;
        e.ctrl   = exp_ctrl(st, op, rdy);
        e.cnt    = exp_cnt;
        e.halted = (st == ST_HALT);
        e.berr   = exp_berr;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic compareField(input string nm, input string field,
                                input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want)
            pass_cnt++;
        else
            $display("[TB] FAIL %s.%s got 0x%0h want 0x%0h", nm, field, got, want);
    endtask

    task automatic checkOutput(input exp_t e, input string nm);
        ctrl_t act;
        act.pc_write      = bus_if.pc_write;
        act.pc_write_cond = bus_if.pc_write_cond;
        act.branch_ne     = bus_if.branch_ne;
        act.iord          = bus_if.iord;
        act.mem_read      = bus_if.mem_read;
        act.mem_write     = bus_if.mem_write;
        act.ir_write      = bus_if.ir_write;
        act.mem_to_reg    = bus_if.mem_to_reg;
        act.reg_dst       = bus_if.reg_dst;
        act.reg_write     = bus_if.reg_write;
        act.alu_src_a     = bus_if.alu_src_a;
        act.alu_src_b     = bus_if.alu_src_b;
        act.alu_op        = bus_if.alu_op;
        act.pc_source     = bus_if.pc_source;
        compareField(nm, "state",       32'(bus_if.state_dbg),   32'(e.st));
        compareField(nm, "ctrl",        32'(act),                32'(e.ctrl));
        compareField(nm, "instr_count", 32'(bus_if.instr_count), 32'(e.cnt));
        compareField(nm, "halted",      32'(bus_if.halted),      32'(e.halted));
        compareField(nm, "bus_error",   32'(bus_if.bus_error),   32'(e.berr));
    endtask

    // Monitor: compare DUT outputs against the oldest expectation mid-cycle
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checkOutput(e, nm);
        end
    end

    // Global time limit
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] time limit reached");
    end

    // Directed stimulus
    initial begin
        rst_n            = 1'b0;
        bus_if.opcode    = OP_R;
        bus_if.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(OP_R, 1'b0, ST_IDLE, "reset0");
        applyStimulus(OP_R, 1'b1, ST_IDLE, "reset1");
        rst_n = 1'b1;
        applyStimulus(OP_R, 1'b1, ST_IDLE, "idle");

        $display("[TB] R-type");
        applyStimulus(OP_R, 1'b1, ST_FETCH,   "r_fetch");
        applyStimulus(OP_R, 1'b1, ST_DECODE,  "r_decode");
        applyStimulus(OP_R, 1'b1, ST_EXECUTE, "r_exec");
        applyStimulus(OP_R, 1'b1, ST_R_WB,    "r_wb");
        exp_cnt = exp_cnt + 1'b1;

        $display("[TB] lw with three MEM_READ wait cycles");
        applyStimulus(OP_LW, 1'b1, ST_FETCH,    "lw_fetch");
        applyStimulus(OP_LW, 1'b0, ST_DECODE,   "lw_decode");
        applyStimulus(OP_LW, 1'b0, ST_MEM_ADDR, "lw_addr");
        for (int i = 0; i < 3; i++)
            applyStimulus(OP_LW, 1'b0, ST_MEM_READ, "lw_read_wait");
        applyStimulus(OP_LW, 1'b1, ST_MEM_READ, "lw_read_done");
        applyStimulus(OP_LW, 1'b0, ST_MEM_WB,   "lw_wb");
        exp_cnt = exp_cnt + 1'b1;

        $display("[TB] sw with one FETCH wait cycle");
        applyStimulus(OP_SW, 1'b0, ST_FETCH,     "sw_fetch_wait");
        applyStimulus(OP_SW, 1'b1, ST_FETCH,     "sw_fetch");
        applyStimulus(OP_SW, 1'b1, ST_DECODE,    "sw_decode");
        applyStimulus(OP_SW, 1'b1, ST_MEM_ADDR,  "sw_addr");
        applyStimulus(OP_SW, 1'b1, ST_MEM_WRITE, "sw_write");
        exp_cnt = exp_cnt + 1'b1;

        $display("[TB] bne then beq");
        applyStimulus(OP_BNE, 1'b1, ST_FETCH,  "bne_fetch");
        applyStimulus(OP_BNE, 1'b1, ST_DECODE, "bne_decode");
        applyStimulus(OP_BNE, 1'b0, ST_BRANCH, "bne_branch");
        exp_cnt = exp_cnt + 1'b1;
        applyStimulus(OP_BEQ, 1'b1, ST_FETCH,  "beq_fetch");
        applyStimulus(OP_BEQ, 1'b1, ST_DECODE, "beq_decode");
        applyStimulus(OP_BEQ, 1'b1, ST_BRANCH, "beq_branch");
        exp_cnt = exp_cnt + 1'b1;

        $display("[TB] addi");
        applyStimulus(OP_ADDI, 1'b1, ST_FETCH,     "addi_fetch");
        applyStimulus(OP_ADDI, 1'b1, ST_DECODE,    "addi_decode");
        applyStimulus(OP_ADDI, 1'b1, ST_ADDI_EXEC, "addi_exec");
        applyStimulus(OP_ADDI, 1'b1, ST_ADDI_WB,   "addi_wb");
        exp_cnt = exp_cnt + 1'b1;

        $display("[TB] jumps through the counter wrap");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(OP_J, 1'b1, ST_FETCH,  "j_fetch");
            applyStimulus(OP_J, 1'b1, ST_DECODE, "j_decode");
            applyStimulus(OP_J, 1'b1, ST_JUMP,   "j_jump");
            exp_cnt = exp_cnt + 1'b1;
        end

        $display("[TB] illegal opcode halts");
        applyStimulus(OP_BAD, 1'b1, ST_FETCH,  "bad_fetch");
        applyStimulus(OP_BAD, 1'b1, ST_DECODE, "bad_decode");
        for (int i = 0; i < 20; i++)
            applyStimulus(OP_BAD, 1'(i % 2), ST_HALT, "bad_halt");
        rst_n   = 1'b0;
        exp_cnt = '0;
        applyStimulus(OP_R, 1'b1, ST_IDLE, "halt_reset");
        rst_n = 1'b1;
        applyStimulus(OP_R, 1'b1, ST_IDLE, "halt_idle");

        $display("[TB] reset during MEM_WRITE");
        applyStimulus(OP_SW, 1'b1, ST_FETCH,     "rsw_fetch");
        applyStimulus(OP_SW, 1'b1, ST_DECODE,    "rsw_decode");
        applyStimulus(OP_SW, 1'b1, ST_MEM_ADDR,  "rsw_addr");
        applyStimulus(OP_SW, 1'b0, ST_MEM_WRITE, "rsw_write_wait");
        bus_if.mem_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        applyStimulus(OP_SW, 1'b0, ST_IDLE, "rsw_async_reset");
        rst_n = 1'b1;
        applyStimulus(OP_SW, 1'b1, ST_IDLE, "rsw_idle");

`ifdef MEM_TIMEOUT_EN
        $display("[TB] watchdog: ready on the last allowed cycle, then timeout");
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++)
            applyStimulus(OP_R, 1'b0, ST_FETCH, "wd_fetch_wait");
        applyStimulus(OP_R, 1'b1, ST_FETCH,   "wd_fetch_last_ok");
        applyStimulus(OP_R, 1'b1, ST_DECODE,  "wd_decode");
        applyStimulus(OP_R, 1'b1, ST_EXECUTE, "wd_exec");
        applyStimulus(OP_R, 1'b1, ST_R_WB,    "wd_wb");
        exp_cnt = exp_cnt + 1'b1;
        for (int i = 0; i < TIMEOUT_CYCLES; i++)
            applyStimulus(OP_R, 1'b0, ST_FETCH, "wd_fetch_stall");
        exp_berr = 1'b1;
        applyStimulus(OP_R, 1'b1, ST_HALT, "wd_halt0");
        applyStimulus(OP_R, 1'b0, ST_HALT, "wd_halt1");
        rst_n    = 1'b0;
        exp_berr = 1'b0;
        exp_cnt  = '0;
        applyStimulus(OP_R, 1'b1, ST_IDLE, "wd_reset");
        rst_n = 1'b1;
        applyStimulus(OP_R, 1'b1, ST_IDLE, "wd_idle");
`else
        $display("[TB] no watchdog: FETCH waits indefinitely");
        for (int i = 0; i < 3 * TIMEOUT_CYCLES; i++)
            applyStimulus(OP_R, 1'b0, ST_FETCH, "nowd_fetch_stall");
        applyStimulus(OP_R, 1'b1, ST_FETCH,   "nowd_fetch");
        applyStimulus(OP_R, 1'b1, ST_DECODE,  "nowd_decode");
        applyStimulus(OP_R, 1'b1, ST_EXECUTE, "nowd_exec");
        applyStimulus(OP_R, 1'b1, ST_R_WB,    "nowd_wb");
        exp_cnt = exp_cnt + 1'b1;
        applyStimulus(OP_R, 1'b1, ST_FETCH,   "nowd_fetch_next");
`endif

        @(negedge clk);
        #1;
        compareField("scoreboard", "pending", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
